// File: rtl/ads1672_pkg.sv
// Shared types and width helpers for the ADS1672 measurement scheduler.
package ads1672_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, RESP} sched_state_t;

  function automatic int idx_w(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  function automatic int cnt_w(input int timeout_cycles);
    return (timeout_cycles > 1) ? $clog2(timeout_cycles) : 1;
  endfunction

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_TIMEOUT = 4096;
  localparam int DEF_IDX_W   = idx_w(DEF_NUM_REQ);
  localparam int DEF_CNT_W   = cnt_w(DEF_TIMEOUT);

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first pending bit after last_grant, wrapping.
module rr_arbiter
  import ads1672_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]        pending,
  input  logic [idx_w(NUM_REQ)-1:0] last_grant,
  output logic                      grant_valid,
  output logic [idx_w(NUM_REQ)-1:0] grant_idx
);

  localparam int IW = idx_w(NUM_REQ);

  always_comb begin : arb
    logic [IW-1:0] idx;
    idx         = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    // Offset NUM_REQ lands back on last_grant, so it is checked last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = IW'((int'(last_grant) + k) % NUM_REQ);
      if (!grant_valid && pending[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx;
      end
    end
  end

endmodule

// File: rtl/ads1672_scheduler.sv
// Serialises requester pulses into single ADC measure pulses and routes each
// sample (or a timeout) back to the requester that was granted.
module ads1672_scheduler
  import ads1672_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 24,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  output logic [NUM_REQ-1:0]        resp_valid,
  output logic [DATA_WIDTH-1:0]     resp_data,
  output logic                      resp_timeout,
  output logic [idx_w(NUM_REQ)-1:0] grant_id,
  output logic                      busy,
  output logic                      adc_measure,
  input  logic [DATA_WIDTH-1:0]     adc_data,
  input  logic                      adc_data_valid
);

  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = cnt_w(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  sched_state_t        state, state_d;
  logic [NUM_REQ-1:0]  pending, grant_mask;
  logic [IW-1:0]       last_grant, grant_idx;
  logic                grant_valid, take, cnt_done;
  logic [CW-1:0]       cnt;
  logic                timeout_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .pending     (pending),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign cnt_done = (cnt == CNT_LAST);

  always_comb begin
    state_d    = state;
    take       = 1'b0;
    grant_mask = '0;
    case (state)
      IDLE: if (grant_valid) begin
        state_d    = ISSUE;
        take       = 1'b1;
        grant_mask = NUM_REQ'(1) << grant_idx;
      end
      ISSUE:     state_d = WAIT_DATA;
      WAIT_DATA: if (adc_data_valid || cnt_done) state_d = RESP;
      RESP:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pending    <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      grant_id   <= '0;
      cnt        <= '0;
      resp_data  <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state   <= state_d;
      // A request landing on the grant cycle re-queues the requester.
      pending <= (pending & ~grant_mask) | req;
      if (take) begin
        grant_id   <= grant_idx;
        last_grant <= grant_idx;
      end
      if (state == ISSUE)
        cnt <= '0;
      else if (state == WAIT_DATA && !cnt_done)
        cnt <= cnt + 1'b1;
      if (state == WAIT_DATA) begin
        if (adc_data_valid) begin
          resp_data <= adc_data;
          timeout_q <= 1'b0;
        end else if (cnt_done) begin
          resp_data <= '0;
          timeout_q <= 1'b1;
        end
      end
    end
  end

  assign adc_measure  = (state == ISSUE);
  assign busy         = (state != IDLE);
  assign resp_valid   = (state == RESP) ? (NUM_REQ'(1) << grant_id) : '0;
  assign resp_timeout = (state == RESP) && timeout_q;

endmodule

// File: tb/tb_ads1672_scheduler.sv
// Bench: main instance with a latency-programmable reader model and a response
// scoreboard; a second instance with a short timeout for the timeout corners.
module tb_ads1672_scheduler;
  localparam int NR = 4;
  localparam int DW = 24;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // main instance
  logic [NR-1:0] req;
  logic [NR-1:0] resp_valid;
  logic [DW-1:0] resp_data, adc_data;
  logic          resp_timeout, busy, adc_measure, adc_data_valid;
  logic [1:0]    grant_id;

  ads1672_scheduler #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(64)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .resp_valid(resp_valid),
    .resp_data(resp_data), .resp_timeout(resp_timeout), .grant_id(grant_id),
    .busy(busy), .adc_measure(adc_measure), .adc_data(adc_data),
    .adc_data_valid(adc_data_valid)
  );

  // short-timeout instance
  logic [NR-1:0] t_req;
  logic [NR-1:0] t_resp_valid;
  logic [DW-1:0] t_resp_data, t_adc_data;
  logic          t_resp_timeout, t_busy, t_adc_measure, t_adc_valid;
  logic [1:0]    t_grant_id;

  ads1672_scheduler #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(16)) u_tmo (
    .clk(clk), .rst_n(rst_n), .req(t_req), .resp_valid(t_resp_valid),
    .resp_data(t_resp_data), .resp_timeout(t_resp_timeout), .grant_id(t_grant_id),
    .busy(t_busy), .adc_measure(t_adc_measure), .adc_data(t_adc_data),
    .adc_data_valid(t_adc_valid)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]    id;
    logic [DW-1:0] data;
    logic          tmo;
  } exp_t;
  exp_t sb[$];

  // Reader model: returns rd_base + (measure index) rd_lat cycles after measure.
  logic [DW-1:0] rd_base;
  int            rd_lat;
  int            rd_cd;
  int            mcount;
  logic [DW-1:0] rd_word;
  always @(negedge clk) begin
    adc_data_valid = 1'b0;
    if (!rst_n) begin
      rd_cd  = 0;
      mcount = 0;
    end else begin
      if (rd_cd > 0) begin
        rd_cd--;
        if (rd_cd == 0) begin
          adc_data       = rd_word;
          adc_data_valid = 1'b1;
        end
      end
      if (adc_measure) begin
        rd_word = rd_base + DW'(mcount);
        rd_cd   = rd_lat;
        mcount++;
      end
    end
  end

  // Response monitor: every response must match the head of the scoreboard.
  int resp_seen = 0;
  always @(negedge clk) begin
    if (rst_n && resp_valid !== '0) begin
      exp_t e;
      resp_seen++;
      if (sb.size() == 0) begin
        chk("unexpected_resp", 32'(resp_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("resp_valid", 32'(resp_valid), 32'(1) << e.id);
        chk("resp_data", 32'(resp_data), 32'(e.data));
        chk("resp_timeout", 32'(resp_timeout), 32'(e.tmo));
      end
    end
  end

  task automatic push(input logic [1:0] id, input logic [DW-1:0] data, input logic tmo);
    exp_t e;
    e.id = id; e.data = data; e.tmo = tmo;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_data"}, 32'(resp_data), 32'd0);
    chk({tag, "_resp_timeout"}, 32'(resp_timeout), 32'd0);
    chk({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_adc_measure"}, 32'(adc_measure), 32'd0);
  endtask

  // wait (bounded) for a short-timeout instance signal, returning cycles waited
  task automatic t_wait_measure(output int n);
    n = 0;
    while (!t_adc_measure && n < 20) begin @(negedge clk); n++; end
    chk("t_measure_seen", 32'(t_adc_measure), 32'd1);
  endtask

  task automatic t_wait_resp(input int start, output int n);
    n = start;
    while (t_resp_valid == '0 && n < 60) begin @(negedge clk); n++; end
  endtask

  typedef struct {
    logic [NR-1:0] req;
    int            n;
    logic [7:0]    ord;   // grant order, 2 bits per slot, slot 0 in LSBs
  } vec_t;
  vec_t vecs[6];

  initial begin
    int n;
    vecs[0] = '{4'b0010, 1, 8'h01};
    vecs[1] = '{4'b1111, 4, 8'hE4};
    vecs[2] = '{4'b0101, 2, 8'h08};
    vecs[3] = '{4'b1000, 1, 8'h03};
    vecs[4] = '{4'b0110, 2, 8'h09};
    vecs[5] = '{4'b1001, 2, 8'h0C};

    rst_n = 1'b1; req = '0; t_req = '0; t_adc_valid = 1'b0; t_adc_data = '0;
    rd_base = '0; rd_lat = 5;
    #2 rst_n = 1'b0;
    #1 chk_all_zero("reset");
    do_reset();

    // single request, exact timing, 30-cycle reader
    rd_base = 24'hABCDEF; rd_lat = 30;
    push(2'd1, 24'hABCDEF, 1'b0);
    req = 4'b0010;
    @(negedge clk); req = '0;
    chk("single_c1_measure", 32'(adc_measure), 32'd0);
    chk("single_c1_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("single_c2_measure", 32'(adc_measure), 32'd1);
    chk("single_c2_busy", 32'(busy), 32'd1);
    chk("single_c2_grant", 32'(grant_id), 32'd1);
    drain(100);

    // table-driven request patterns, each from reset
    for (int v = 0; v < 6; v++) begin
      do_reset();
      rd_base = DW'(24'h100000 * (v + 1));
      rd_lat  = 5 + v;
      for (int k = 0; k < vecs[v].n; k++)
        push(vecs[v].ord[2*k +: 2], rd_base + DW'(k), 1'b0);
      req = vecs[v].req;
      @(negedge clk); req = '0;
      drain(300);
      repeat (10) @(negedge clk);
      chk("vec_measures", 32'(mcount), 32'(vecs[v].n));
    end

    // fairness: req0 held for 10 cycles, req2 once
    do_reset();
    rd_base = 24'h200000; rd_lat = 5;
    push(2'd0, 24'h200000, 1'b0);
    push(2'd2, 24'h200001, 1'b0);
    push(2'd0, 24'h200002, 1'b0);
    req = 4'b0101;
    @(negedge clk); req = 4'b0001;
    repeat (9) @(negedge clk);
    req = '0;
    drain(200);
    repeat (20) @(negedge clk);
    chk("fair_measures", 32'(mcount), 32'd3);

    // request on the grant cycle is re-queued
    do_reset();
    rd_base = 24'h300000; rd_lat = 4;
    push(2'd0, 24'h300000, 1'b0);
    push(2'd0, 24'h300001, 1'b0);
    req = 4'b0001;
    @(negedge clk);
    @(negedge clk); req = '0;
    drain(200);
    repeat (20) @(negedge clk);
    chk("requeue_measures", 32'(mcount), 32'd2);

    // reset during WAIT_DATA
    do_reset();
    rd_base = 24'h400000; rd_lat = 30;
    req = 4'b0100;
    @(negedge clk); req = '0;
    repeat (4) @(negedge clk);
    chk("midrst_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = resp_seen;
    repeat (40) @(negedge clk);
    chk("midrst_no_resp", 32'(resp_seen), 32'(n));
    push(2'd3, 24'h400000, 1'b0);
    req = 4'b1000;
    @(negedge clk); req = '0;
    drain(100);

    // timeout: response TIMEOUT_CYCLES+1 after ISSUE
    do_reset();
    t_req = 4'b0010;
    @(negedge clk); t_req = '0;
    t_wait_measure(n);
    t_wait_resp(0, n);
    chk("tmo_latency", 32'(n), 32'd17);
    chk("tmo_valid", 32'(t_resp_valid), 32'b0010);
    chk("tmo_flag", 32'(t_resp_timeout), 32'd1);
    chk("tmo_data", 32'(t_resp_data), 32'd0);

    // stale valid during ISSUE must be ignored
    t_req = 4'b0100;
    @(negedge clk); t_req = '0;
    t_wait_measure(n);
    t_adc_valid = 1'b1; t_adc_data = 24'h123456;
    @(negedge clk); t_adc_valid = 1'b0;
    t_wait_resp(1, n);
    chk("stale_latency", 32'(n), 32'd17);
    chk("stale_valid", 32'(t_resp_valid), 32'b0100);
    chk("stale_flag", 32'(t_resp_timeout), 32'd1);
    chk("stale_data", 32'(t_resp_data), 32'd0);

    // valid on the terminal timeout cycle wins
    @(negedge clk);
    t_req = 4'b0001;
    @(negedge clk); t_req = '0;
    t_wait_measure(n);
    repeat (16) @(negedge clk);
    t_adc_valid = 1'b1; t_adc_data = 24'h5A5A5A;
    @(negedge clk); t_adc_valid = 1'b0;
    chk("term_valid", 32'(t_resp_valid), 32'b0001);
    chk("term_flag", 32'(t_resp_timeout), 32'd0);
    chk("term_data", 32'(t_resp_data), 32'h5A5A5A);
    @(negedge clk);
    chk("term_idle", 32'(t_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
